mem_mgr_noc_encoder: RTL

//  Response-side NoC packet builder for the DRAM tile memory manager; the egress counterpart of the

---
 rtl/mem_mgr_noc_pkg.sv | 44 ++++
 rtl/mem_mgr_resp_fifo.sv | 45 ++++
 rtl/mem_mgr_noc_encoder.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mem_mgr_noc_pkg.sv
// Shared NoC definitions for the memory-manager ingress decoder and egress encoder.
// Covers packet codes, the header layout and the encoder state encoding.
// No logic; no latency or backpressure of its own.
package mem_mgr_noc_pkg;

    localparam logic [2:0] NOC_MACK   = 3'd1;
    localparam logic [2:0] NOC_MDATA  = 3'd2;
    localparam logic [2:0] NOC_MPUT   = 3'd4;
    localparam logic [2:0] NOC_MGET   = 3'd5;
    localparam logic [2:0] NOC_MLOAD  = 3'd6;
    localparam logic [2:0] NOC_MSTORE = 3'd7;

    // body carries the offset for short packets, {6'b0, len_log2, 2'b0} for long ones
    typedef struct packed {
        logic [2:0]  rsvd_hi;
        logic        hl;
        logic [2:0]  code;
        logic [6:0]  rsvd_mid;
        logic [11:0] body;
        logic [5:0]  dst;
    } noc_hdr_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_ADDR,
        ST_DATA,
        ST_ACK_WORD,
        ST_DROP
    } enc_state_t;

    function automatic noc_hdr_t build_hdr(input logic hl, input logic [2:0] code,
                                           input logic [11:0] offset, input logic [3:0] len_log2,
                                           input logic [5:0] dst);
        noc_hdr_t h;
        h      = '0;
        h.hl   = hl;
        h.code = code;
        h.body = hl ? {6'b0, len_log2, 2'b0} : offset;
        h.dst  = dst;
        return h;
    endfunction

endpackage

// File: rtl/mem_mgr_resp_fifo.sv
// Synchronous read-data FIFO with asynchronous clear.
// Latency: a pushed word is at the head on the following cycle.
// Backpressure: push ignored when full, pop ignored when empty.
module mem_mgr_resp_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clk_ctrl,
    input  logic             clk_ctrl_rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign wr_en    = push && !full;
    assign rd_en    = pop && !empty;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_ctrl) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

    always_ff @(posedge clk_ctrl or posedge clk_ctrl_rst) begin
        if (clk_ctrl_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/mem_mgr_noc_encoder.sv
// Builds NoC response packets (MDATA / MACK) from response jobs and buffered cache read data.
// Latency: header one cycle after job accept; data beats one cycle after their FIFO push at the earliest.
// Backpressure: AXIS TREADY stalls the FSM; cpu_resp_ready drops while the read-data FIFO is full.
module mem_mgr_noc_encoder
    import mem_mgr_noc_pkg::*;
#(
    parameter int S_AXI_ID_SZ  = 11,
    parameter int FIFO_DEPTH   = 16,
    parameter int MAX_LEN_LOG2 = 4
) (
    input  logic                    clk_ctrl,
    input  logic                    clk_ctrl_rst,
    input  logic                    job_valid,
    output logic                    job_ready,
    input  logic [2:0]              job_code,
    input  logic [5:0]              job_dst,
    input  logic [11:0]             job_offset,
    input  logic [31:0]             job_addr,
    input  logic [MAX_LEN_LOG2-1:0] job_len_log2,
    input  logic [S_AXI_ID_SZ-1:0]  job_id,
    input  logic                    cpu_resp_valid,
    input  logic [31:0]             cpu_resp_data,
    output logic                    cpu_resp_ready,
    output logic                    stream_out_TVALID,
    output logic [31:0]             stream_out_TDATA,
    output logic [3:0]              stream_out_TKEEP,
    output logic                    stream_out_TLAST,
    input  logic                    stream_out_TREADY
);
    localparam int CW = MAX_LEN_LOG2 + 1;

    enc_state_t             state;
    noc_hdr_t               hdr_q;
    logic [31:0]            addr_q;
    logic [S_AXI_ID_SZ-1:0] id_q;
    logic [CW-1:0]          cnt_q;
    logic                   ack_q;

    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_pop;
    logic [31:0]            fifo_head;
    logic                   is_long;

    assign is_long          = (job_len_log2 != '0);
    assign cpu_resp_ready   = !fifo_full;
    assign stream_out_TKEEP = 4'hF;

    mem_mgr_resp_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_resp_fifo (
        .clk_ctrl     (clk_ctrl),
        .clk_ctrl_rst (clk_ctrl_rst),
        .push         (cpu_resp_valid),
        .push_dat     (cpu_resp_data),
        .pop          (fifo_pop),
        .head_dat     (fifo_head),
        .full         (fifo_full),
        .empty        (fifo_empty)
    );

    always_comb begin
        stream_out_TVALID = 1'b0;
        stream_out_TDATA  = '0;
        stream_out_TLAST  = 1'b0;
        fifo_pop          = 1'b0;
        case (state)
            ST_HDR: begin
                stream_out_TVALID = 1'b1;
                stream_out_TDATA  = hdr_q;
            end
            ST_ADDR: begin
                stream_out_TVALID = 1'b1;
                stream_out_TDATA  = addr_q;
            end
            ST_DATA: begin
                stream_out_TVALID = !fifo_empty;
                stream_out_TDATA  = fifo_empty ? '0 : fifo_head;
                stream_out_TLAST  = !fifo_empty && (cnt_q == CW'(1));
                fifo_pop          = !fifo_empty && stream_out_TREADY;
            end
            ST_ACK_WORD: begin
                stream_out_TVALID = 1'b1;
                stream_out_TDATA  = {{(32-S_AXI_ID_SZ){1'b0}}, id_q};
                stream_out_TLAST  = 1'b1;
            end
            default: ;
        endcase
    end

    // job_ready only re-arms after a full cycle back in IDLE
    always_ff @(posedge clk_ctrl or posedge clk_ctrl_rst) begin
        if (clk_ctrl_rst) begin
            state     <= ST_IDLE;
            job_ready <= 1'b0;
            hdr_q     <= '0;
            addr_q    <= '0;
            id_q      <= '0;
            cnt_q     <= '0;
            ack_q     <= 1'b0;
        end else begin
            job_ready <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (job_valid && job_ready) begin
                        addr_q <= job_addr;
                        id_q   <= job_id;
                        cnt_q  <= CW'(1) << job_len_log2;
                        ack_q  <= 1'b0;
                        hdr_q  <= '0;
                        case (job_code)
                            NOC_MGET, NOC_MLOAD: begin
                                hdr_q <= build_hdr(is_long, NOC_MDATA, job_offset,
                                                   4'(job_len_log2), job_dst);
                                state <= ST_HDR;
                            end
                            NOC_MSTORE: begin
                                hdr_q <= build_hdr(1'b0, NOC_MACK, job_offset,
                                                   4'(job_len_log2), job_dst);
                                ack_q <= 1'b1;
                                state <= ST_HDR;
                            end
                            default: state <= ST_DROP;
                        endcase
                    end else begin
                        job_ready <= 1'b1;
                    end
                end
                ST_HDR: begin
                    if (stream_out_TREADY) begin
                        if (hdr_q.hl)   state <= ST_ADDR;
                        else if (ack_q) state <= ST_ACK_WORD;
                        else            state <= ST_DATA;
                    end
                end
                ST_ADDR: begin
                    if (stream_out_TREADY) state <= ST_DATA;
                end
                ST_DATA: begin
                    if (fifo_pop) begin
                        cnt_q <= cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) state <= ST_IDLE;
                    end
                end
                ST_ACK_WORD: begin
                    if (stream_out_TREADY) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
